// File: rtl/data_mem_responder.sv
// data_mem_responder: word memory with a fixed-latency read response pipe.
// Define MEM_CLEAR_ON_RESET_EN to zero the whole array after every reset.
module data_mem_responder #(
   parameter int WORDS_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic [15:0] rsp_addr
);

   localparam int DEPTH = 1 << WORDS_LOG2;

   logic [15:0]           mem_q [DEPTH];
   logic [WORDS_LOG2-1:0] idx;
   logic                  acc;
   logic                  rd_acc;
   logic                  wr_acc;
   logic                  mem_we;
   logic [WORDS_LOG2-1:0] mem_waddr;
   logic [15:0]           mem_wdata;
   logic [LATENCY-1:0]    vld_q;
   logic [LATENCY-1:0]    vld_d;
   logic [15:0]           dat_q [LATENCY];
   logic [15:0]           dat_d [LATENCY];
   logic [15:0]           adr_q [LATENCY];
   logic [15:0]           adr_d [LATENCY];
   logic                  unused_addr;

   // Bit 0 and the bits above the index alias onto the same word.
   assign idx         = req_addr[WORDS_LOG2:1];
   assign unused_addr = ^{req_addr[15:WORDS_LOG2+1], req_addr[0]};

   assign acc    = req_valid & req_ready;
   assign rd_acc = acc & ~req_wr;
   assign wr_acc = acc & req_wr;

`ifdef MEM_CLEAR_ON_RESET_EN
   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_e;

   state_e                state_q;
   state_e                state_d;
   logic [WORDS_LOG2-1:0] clr_q;
   logic [WORDS_LOG2-1:0] clr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      unique case (state_q)
         CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == '1) begin
               state_d = READY;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_comb begin
      req_ready = (state_q == READY);
   end
`else
   always_comb begin
      req_ready = 1'b1;
   end
`endif

   // The clear sequencer borrows the write port while requests are blocked.
   always_comb begin
      mem_we    = wr_acc;
      mem_waddr = idx;
      mem_wdata = req_wdata;
`ifdef MEM_CLEAR_ON_RESET_EN
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_q;
         mem_wdata = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // Data/addr only move with a valid bit, so the last stage holds
   // the previous response while rsp_valid is low.
   always_comb begin
      vld_d    = '0;
      vld_d[0] = rd_acc;
      dat_d[0] = dat_q[0];
      adr_d[0] = adr_q[0];
      if (rd_acc) begin
         dat_d[0] = mem_q[idx];
         adr_d[0] = req_addr;
      end
      for (int i = 1; i < LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i];
         adr_d[i] = adr_q[i];
         if (vld_q[i-1]) begin
            dat_d[i] = dat_q[i-1];
            adr_d[i] = adr_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= '0;
            adr_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < LATENCY; i++) begin
            dat_q[i] <= dat_d[i];
            adr_q[i] <= adr_d[i];
         end
      end
   end

   assign rsp_valid = vld_q[LATENCY-1];
   assign rsp_rdata = dat_q[LATENCY-1];
   assign rsp_addr  = adr_q[LATENCY-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder.
// Also covers the MEM_CLEAR_ON_RESET_EN build when that macro is defined.
module tb_data_mem_responder;

   localparam int WL  = 10;
   localparam int LAT = 4;
   localparam int NW  = 1 << WL;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [15:0] rsp_addr;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      int          c;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem_m [NW];
   logic [15:0] last_d;
   logic [15:0] last_a;
   int          cyc;
   int          tests;
   int          fails;

   data_mem_responder #(
      .WORDS_LOG2(WL),
      .LATENCY   (LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_wr   (req_wr),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_addr (rsp_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic int widx(logic [15:0] a);
      return int'(a[WL:1]);
   endfunction

   // Called at posedge+2; leaves the bench at the next posedge+2.
   task automatic issue(bit wr, logic [15:0] a, logic [15:0] d);
      int g;
      exp_t e;
      g = 0;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      while (!req_ready && g < 5000) begin
         @(posedge clk);
         #2;
         g++;
      end
      if (!req_ready) begin
         check("issue_timeout", 32'd0, 32'd1);
      end else if (wr) begin
         mem_m[widx(a)] = d;
      end else begin
         e.a = a;
         e.d = mem_m[widx(a)];
         e.c = cyc + LAT;
         sb.push_back(e);
      end
      @(posedge clk);
      #2;
      req_valid = 1'b0;
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 50) begin
         @(posedge clk);
         #2;
         g++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   task automatic wait_ready();
`ifdef MEM_CLEAR_ON_RESET_EN
      int n;
      n = 0;
      while (!req_ready && n < 5000) begin
         n++;
         @(posedge clk);
         #2;
      end
      check("clear_cycles", n, NW);
      for (int i = 0; i < NW; i++) mem_m[i] = '0;
`else
      check("ready_after_reset", {31'd0, req_ready}, 32'd1);
`endif
   endtask

   // Monitor: pops the scoreboard whenever a response is presented.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            check("rst_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
            check("rst_addr", {16'd0, rsp_addr}, 32'd0);
            sb.delete();
            last_d = '0;
            last_a = '0;
         end else if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.d});
               check("rsp_addr", {16'd0, rsp_addr}, {16'd0, e.a});
               check("rsp_cycle", cyc, e.c);
               last_d = e.d;
               last_a = e.a;
            end
         end else begin
            check("hold_rdata", {16'd0, rsp_rdata}, {16'd0, last_d});
            check("hold_addr", {16'd0, rsp_addr}, {16'd0, last_a});
         end
      end
   end

   initial begin
      logic [15:0] a;
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      last_d    = '0;
      last_a    = '0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      wait_ready();

`ifdef MEM_CLEAR_ON_RESET_EN
      issue(0, 16'h07FE, 16'h0);
      drain();
`else
      for (int i = 0; i < NW; i++) begin
         a = 16'(i * 2);
         issue(1, a, 16'($urandom));
      end
`endif

      issue(1, 16'h0010, 16'h1234);
      issue(0, 16'h0010, 16'h0);
      drain();

      for (int i = 0; i < 8; i++) begin
         a = 16'(2 * i);
         issue(1, a, 16'hA000 + 16'(i));
      end
      for (int i = 0; i < 8; i++) begin
         a = 16'(2 * i);
         issue(0, a, 16'h0);
      end
      drain();

      issue(1, 16'h0020, 16'h1111);
      issue(0, 16'h0020, 16'h0);
      issue(1, 16'h0020, 16'h2222);
      issue(0, 16'h0020, 16'h0);
      drain();

      issue(1, 16'h0003, 16'hBEEF);
      issue(0, 16'h0002, 16'h0);
      issue(0, 16'h0802, 16'h0);
      drain();

      for (int i = 0; i < 400; i++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            idle(1);
         end else if ($urandom_range(0, 1) == 0) begin
            issue(1, a, 16'($urandom));
         end else begin
            issue(0, a, 16'h0);
         end
      end
      drain();

      issue(0, 16'h0010, 16'h0);
      issue(0, 16'h0012, 16'h0);
      issue(0, 16'h0014, 16'h0);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("async_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
      check("async_rst_addr", {16'd0, rsp_addr}, 32'd0);
      #1;
      idle(2);
      rst_n = 1'b1;
      wait_ready();
      idle(10);
`ifdef MEM_CLEAR_ON_RESET_EN
      issue(0, 16'h0010, 16'h0);
`else
      issue(1, 16'h0010, 16'h5A5A);
      issue(0, 16'h0010, 16'h0);
`endif
      drain();
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
